sigframer: RTL and testbench

Antenna-sample framer in the `sig_clk` domain. It drives the valid/I/Q input of the correlator signal buffer. Raw per-antenna sample strobes become a stream made only of whole blocks of `COUNT` samples, so bank switches downstream always align with block boundaries. A start/stop request from control takes effect only on block boundaries. Built-in test-pattern sources (zeros, counting, LFSR) replace live data for bring-up and bench checks.

---
 rtl/sigframer.sv | 137 +++++++++++++
 tb/tb_sigframer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sigframer.sv
// Antenna-sample framer: turns raw strobes into whole COUNT-sample blocks,
// with block-aligned start/stop and built-in test-pattern sources.
module sigframer #(
  parameter int               WIDTH = 32,
  parameter int               CBITS = 4,
  parameter int               COUNT = 15,
  parameter int               NBITS = 16,
  parameter logic [WIDTH-1:0] POLY  = 32'h0040_0007,
  parameter logic [WIDTH-1:0] SEED  = 32'h0000_0001
) (
  input  logic             sig_clk,
  input  logic             reset_n,
  input  logic             enable_i,
  input  logic [1:0]       mode_i,
  input  logic             strobe_i,
  input  logic [WIDTH-1:0] idata_i,
  input  logic [WIDTH-1:0] qdata_i,
  output logic             valid_o,
  output logic             first_o,
  output logic             last_o,
  output logic [WIDTH-1:0] idata_o,
  output logic [WIDTH-1:0] qdata_o,
  output logic             busy_o,
  output logic [NBITS-1:0] blocks_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [CBITS-1:0] CLAST = CBITS'(COUNT - 1);

  state_t           state;
  state_t           state_nx;
  logic [CBITS-1:0] cnt;
  logic [1:0]       mode_q;
  logic [1:0]       mode_sel;
  logic [WIDTH-1:0] pcnt;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] lfsr_nx;
  logic [WIDTH-1:0] src_i;
  logic [WIDTH-1:0] src_q;
  logic             acc;
  logic             is_first;
  logic             is_last;
  logic             start;

  assign acc      = strobe_i && (state != IDLE);
  assign is_first = (cnt == '0);
  assign is_last  = (cnt == CLAST);
  assign start    = (state == IDLE) && enable_i;
  // Sample 0 uses the live mode input; the rest of the block uses the latch.
  assign mode_sel = is_first ? mode_i : mode_q;
  assign lfsr_nx  = {lfsr[WIDTH-2:0], 1'b0}
                  ^ (lfsr[WIDTH-1] ? POLY : '0);

  always_ff @(posedge sig_clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (enable_i) state_nx = RUN;
      RUN: begin
        if (!enable_i)
          state_nx = (acc && is_last) ? IDLE : STOP;
      end
      STOP: begin
        if (enable_i)               state_nx = RUN;
        else if (acc && is_last)    state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != IDLE);
  end

  always_comb begin
    src_i = idata_i;
    src_q = qdata_i;
    unique case (mode_sel)
      2'd0: begin src_i = idata_i; src_q = qdata_i; end
      2'd1: begin src_i = '0;      src_q = '0;      end
      2'd2: begin src_i = pcnt;    src_q = ~pcnt;   end
      2'd3: begin src_i = lfsr;    src_q = ~lfsr;   end
      default: ;
    endcase
  end

  always_ff @(posedge sig_clk) begin
    if (!reset_n) begin
      cnt    <= '0;
      mode_q <= 2'd0;
      pcnt   <= '0;
      lfsr   <= SEED;
    end else if (start) begin
      cnt  <= '0;
      pcnt <= '0;
      lfsr <= SEED;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (acc) begin
      cnt  <= is_last ? '0 : cnt + 1'b1;
      pcnt <= pcnt + 1'b1;
      lfsr <= lfsr_nx;
      if (is_first) mode_q <= mode_i;
    end
  end

  always_ff @(posedge sig_clk) begin
    if (!reset_n) begin
      valid_o  <= 1'b0;
      first_o  <= 1'b0;
      last_o   <= 1'b0;
      idata_o  <= '0;
      qdata_o  <= '0;
      blocks_o <= '0;
    end else begin
      valid_o <= acc;
      first_o <= acc && is_first;
      last_o  <= acc && is_last;
      if (acc) begin
        idata_o <= src_i;
        qdata_o <= src_q;
      end
      if (acc && is_last && (blocks_o != '1))
        blocks_o <= blocks_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_sigframer.sv
// Scoreboard bench for sigframer: a cycle model predicts each accepted
// sample, the expectation is queued and popped when valid_o appears.
module tb_sigframer;

  localparam int          W    = 32;
  localparam int          CNT  = 15;
  localparam logic [W-1:0] POLY = 32'h0040_0007;
  localparam logic [W-1:0] SEED = 32'h0000_0001;

  logic         sig_clk;
  logic         reset_n;
  logic         enable_i;
  logic [1:0]   mode_i;
  logic         strobe_i;
  logic [W-1:0] idata_i;
  logic [W-1:0] qdata_i;
  logic         valid_o;
  logic         first_o;
  logic         last_o;
  logic [W-1:0] idata_o;
  logic [W-1:0] qdata_o;
  logic         busy_o;
  logic [15:0]  blocks_o;

  sigframer dut (
    .sig_clk  (sig_clk),
    .reset_n  (reset_n),
    .enable_i (enable_i),
    .mode_i   (mode_i),
    .strobe_i (strobe_i),
    .idata_i  (idata_i),
    .qdata_i  (qdata_i),
    .valid_o  (valid_o),
    .first_o  (first_o),
    .last_o   (last_o),
    .idata_o  (idata_o),
    .qdata_o  (qdata_o),
    .busy_o   (busy_o),
    .blocks_o (blocks_o)
  );

  initial sig_clk = 1'b0;
  always #5 sig_clk = ~sig_clk;

  typedef struct packed {
    logic         f;
    logic         l;
    logic [W-1:0] i;
    logic [W-1:0] q;
  } exp_t;

  exp_t q_exp[$];

  int           mst;
  int           mcnt;
  logic [1:0]   mmode;
  logic [W-1:0] mpcnt;
  logic [W-1:0] mlfsr;
  logic [15:0]  mblk;
  int           nchk;
  int           nfail;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] step(input logic [W-1:0] l);
    return {l[W-2:0], 1'b0} ^ (l[W-1] ? POLY : '0);
  endfunction

  task automatic rst();
    reset_n  = 1'b0;
    enable_i = 1'b1;
    strobe_i = 1'b1;
    @(posedge sig_clk);
    #1;
    reset_n  = 1'b1;
    enable_i = 1'b0;
    strobe_i = 1'b0;
    mst   = 0;
    mcnt  = 0;
    mmode = 2'd0;
    mpcnt = '0;
    mlfsr = SEED;
    mblk  = '0;
    q_exp.delete();
    chk("rst_valid", valid_o, 0);
    chk("rst_first", first_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_idata", idata_o, 0);
    chk("rst_qdata", qdata_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_blocks", blocks_o, 0);
  endtask

  task automatic cyc(input bit en, input logic [1:0] md, input bit st,
                     input logic [W-1:0] id, input logic [W-1:0] qd);
    exp_t       e;
    exp_t       g;
    bit         acc;
    bit         lst;
    logic [1:0] m;
    enable_i = en;
    mode_i   = md;
    strobe_i = st;
    idata_i  = id;
    qdata_i  = qd;
    acc = st && (mst != 0);
    lst = (mcnt == CNT - 1);
    if (acc) begin
      m = (mcnt == 0) ? md : mmode;
      if (mcnt == 0) mmode = md;
      e.f = (mcnt == 0);
      e.l = lst;
      case (m)
        2'd0:    begin e.i = id;    e.q = qd;     end
        2'd1:    begin e.i = '0;    e.q = '0;     end
        2'd2:    begin e.i = mpcnt; e.q = ~mpcnt; end
        default: begin e.i = mlfsr; e.q = ~mlfsr; end
      endcase
      q_exp.push_back(e);
      mpcnt = mpcnt + 1;
      mlfsr = step(mlfsr);
      mcnt  = lst ? 0 : mcnt + 1;
      if (lst && mblk != 16'hffff) mblk = mblk + 1;
    end
    case (mst)
      0: if (en) begin mst = 1; mpcnt = '0; mlfsr = SEED; end
      1: if (!en) mst = (acc && lst) ? 0 : 2;
      default: begin
        if (en)              mst = 1;
        else if (acc && lst) mst = 0;
      end
    endcase
    @(posedge sig_clk);
    #1;
    chk("valid", valid_o, acc);
    if (valid_o) begin
      if (q_exp.size() > 0) begin
        g = q_exp.pop_front();
        chk("first", first_o, g.f);
        chk("last", last_o, g.l);
        chk("idata", idata_o, g.i);
        chk("qdata", qdata_o, g.q);
      end else begin
        chk("sb_underflow", valid_o, 0);
      end
    end
    chk("busy", busy_o, mst != 0);
    chk("blocks", blocks_o, mblk);
  endtask

  logic [W-1:0] l15;

  initial begin
    nchk     = 0;
    nfail    = 0;
    reset_n  = 1'b0;
    enable_i = 1'b0;
    mode_i   = 2'd0;
    strobe_i = 1'b0;
    idata_i  = '0;
    qdata_i  = '0;
    rst();

    for (int k = 0; k < 12; k++)
      cyc(0, 2'd0, (k % 3) == 0, $urandom, $urandom);

    cyc(1, 2'd0, 1, 32'hdead, 32'hbeef);
    for (int k = 0; k < 30; k++)
      cyc(1, 2'd0, 1, W'(k), ~W'(k));
    chk("blocks_live", blocks_o, 2);

    for (int k = 0; k < 5; k++)
      cyc(1, 2'd0, 1, $urandom, $urandom);
    for (int k = 0; k < 15; k++)
      cyc(0, 2'd0, 1, $urandom, $urandom);
    chk("busy_after_stop", busy_o, 0);
    chk("blocks_stop", blocks_o, 3);

    l15 = SEED;
    for (int k = 0; k < 15; k++) l15 = step(l15);
    cyc(1, 2'd2, 0, '0, '0);
    for (int k = 0; k < 15; k++) begin
      cyc(1, (k == 0) ? 2'd2 : 2'($urandom_range(0, 3)), 1,
          $urandom, $urandom);
      if (k == 0) chk("cnt_first", idata_o, 0);
      if (k == 14) chk("cnt_last", idata_o, 14);
    end
    for (int k = 0; k < 15; k++) begin
      cyc(1, (k == 0) ? 2'd3 : 2'($urandom_range(0, 3)), 1,
          $urandom, $urandom);
      if (k == 0) chk("lfsr_first", idata_o, l15);
    end

    for (int k = 0; k < 30; k++)
      cyc((k >= 3 && k < 8) ? 1'b0 : 1'b1, 2'd0, 1, $urandom, $urandom);
    chk("blocks_cancel", blocks_o, 7);

    for (int k = 0; k < 45; k++)
      cyc(1, 2'd1, (k % 3) == 0, $urandom, $urandom);
    chk("blocks_gap", blocks_o, 8);

    for (int k = 0; k < 7; k++)
      cyc(1, 2'd3, 1, $urandom, $urandom);
    rst();
    cyc(1, 2'd3, 0, '0, '0);
    for (int k = 0; k < 15; k++) begin
      cyc(1, 2'd3, 1, $urandom, $urandom);
      if (k == 0) begin
        chk("lfsr_restart", idata_o, SEED);
        chk("first_restart", first_o, 1);
      end
    end
    chk("blocks_restart", blocks_o, 1);
    cyc(1, 2'd0, 0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
